// File: rtl/io_intr_ctrl.sv
// io_intr_ctrl: multi-channel prioritised interrupt controller on the CPU I/O bus.
//
// Latches rising edges of irq_src into PENDING, masks them with ENABLE, raises
// intr for the lowest-numbered pending-and-enabled channel, and holds that
// channel in service (VECTOR) until software writes EOI.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 PENDING  R, write-1-to-clear (a new edge in the same cycle wins)
//   0x04 ENABLE   R/W
//   0x08 VECTOR   R, bit DATA_W-1 = valid, [4:0] = in-service channel
//   0x0C EOI      W (data ignored), reads 0
//   0x10 MODE     R/W, only with IOIC_LEVEL_MODE_EN (1 = level-sensitive channel)
//
// Optional feature macro: IOIC_LEVEL_MODE_EN
//
// Ports:
//   clk      system clock
//   reset    synchronous active-high reset
//   io_cs    I/O chip select
//   io_rd    read strobe (IO_out is combinational)
//   io_wr    write strobe (takes effect on the clk edge)
//   Address  byte address
//   IO_in    write data
//   IO_out   read data, 0 when not reading this block
//   irq_src  interrupt source lines, synchronous to clk
//   int_ack  CPU acknowledge
//   intr     interrupt request to the CPU
module io_intr_ctrl #(
    parameter int                NUM_CH    = 8,
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hF00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_cs,
    input  logic              io_rd,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] IO_in,
    output logic [DATA_W-1:0] IO_out,
    input  logic [NUM_CH-1:0] irq_src,
    input  logic              int_ack,
    output logic              intr
);

`ifdef IOIC_LEVEL_MODE_EN
    localparam int OFF_W = 3;
`else
    localparam int OFF_W = 2;
`endif
    localparam int DEC_LSB = OFF_W + 2;

    localparam logic [OFF_W-1:0] OFF_PEND = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_ENAB = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_VECT = OFF_W'(2);
    localparam logic [OFF_W-1:0] OFF_EOI  = OFF_W'(3);
`ifdef IOIC_LEVEL_MODE_EN
    localparam logic [OFF_W-1:0] OFF_MODE = OFF_W'(4);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] enable;
    logic [NUM_CH-1:0] mode;
    logic [NUM_CH-1:0] src_q;
    logic              vec_valid;
    logic [4:0]        vec_ch;

    logic              sel;
    logic [OFF_W-1:0]  off;
    logic              wr_pend, wr_enab, wr_eoi, wr_mode;
    logic [NUM_CH-1:0] req;
    logic [4:0]        winner;
    logic [NUM_CH-1:0] set_vec;
    logic [NUM_CH-1:0] w1c_mask;
    logic [NUM_CH-1:0] ack_mask;
    logic              ack_take;
    logic              eoi_take;

    // Address bits below the word and data bits above NUM_CH carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{IO_in, Address[1:0]};

    // Lowest set index wins; scanning downwards leaves the smallest index last.
    function automatic logic [4:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    assign sel = io_cs && (Address[ADDR_W-1:DEC_LSB] == BASE_ADDR[ADDR_W-1:DEC_LSB]);
    assign off = Address[DEC_LSB-1:2];

    assign wr_pend = sel && io_wr && (off == OFF_PEND);
    assign wr_enab = sel && io_wr && (off == OFF_ENAB);
    assign wr_eoi  = sel && io_wr && (off == OFF_EOI);
`ifdef IOIC_LEVEL_MODE_EN
    assign wr_mode = sel && io_wr && (off == OFF_MODE);
`else
    assign wr_mode = 1'b0;
`endif

    assign req    = pending & enable;
    assign winner = lowest_set(req);

    // Level channels re-set every cycle the source is high, which also makes
    // a W1C (or the acknowledge clear) ineffective until the source drops.
    assign set_vec  = (mode & irq_src) | (~mode & irq_src & ~src_q);
    assign w1c_mask = wr_pend ? IO_in[NUM_CH-1:0] : '0;
    assign ack_mask = ack_take ? (NUM_CH'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        intr       = 1'b0;
        ack_take   = 1'b0;
        eoi_take   = 1'b0;
        case (state)
            IDLE: begin
                if (req != '0) state_next = REQ;
            end
            REQ: begin
                intr = 1'b1;
                // Winner is taken in the acknowledge cycle, so a higher
                // priority request that arrived meanwhile is the one served.
                if (req == '0) begin
                    state_next = IDLE;
                end else if (int_ack) begin
                    ack_take   = 1'b1;
                    state_next = SERVICE;
                end
            end
            SERVICE: begin
                if (wr_eoi) begin
                    eoi_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending   <= '0;
            enable    <= '0;
            mode      <= '0;
            src_q     <= '0;
            vec_valid <= 1'b0;
            vec_ch    <= '0;
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~w1c_mask & ~ack_mask) | set_vec;
            if (wr_enab) enable <= IO_in[NUM_CH-1:0];
            if (wr_mode) mode   <= IO_in[NUM_CH-1:0];
            if (ack_take) begin
                vec_valid <= 1'b1;
                vec_ch    <= winner;
            end else if (eoi_take) begin
                vec_valid <= 1'b0;
                vec_ch    <= '0;
            end
        end
    end

    always_comb begin
        IO_out = '0;
        if (sel && io_rd) begin
            case (off)
                OFF_PEND: IO_out[NUM_CH-1:0] = pending;
                OFF_ENAB: IO_out[NUM_CH-1:0] = enable;
                OFF_VECT: begin
                    IO_out[DATA_W-1] = vec_valid;
                    IO_out[4:0]      = vec_ch;
                end
`ifdef IOIC_LEVEL_MODE_EN
                OFF_MODE: IO_out[NUM_CH-1:0] = mode;
`endif
                default:  IO_out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed bench for io_intr_ctrl with hand-computed expected values.
module tb_io_intr_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_cs, io_rd, io_wr;
    logic [11:0] Address;
    logic [31:0] IO_in;
    logic [31:0] IO_out;
    logic [7:0]  irq_src;
    logic        int_ack;
    logic        intr;

    int tests = 0;
    int fails = 0;

    localparam logic [11:0] BASE = 12'hF00;

    io_intr_ctrl #(
        .NUM_CH(8), .ADDR_W(12), .DATA_W(32), .BASE_ADDR(12'hF00)
    ) dut (
        .clk(clk), .reset(reset), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
        .Address(Address), .IO_in(IO_in), .IO_out(IO_out),
        .irq_src(irq_src), .int_ack(int_ack), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] d);
        Address = BASE + off;
        IO_in   = d;
        io_cs   = 1'b1;
        io_wr   = 1'b1;
        tick();
        io_cs   = 1'b0;
        io_wr   = 1'b0;
        IO_in   = '0;
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        Address = addr;
        io_cs   = 1'b1;
        io_rd   = 1'b1;
        #1;
        d       = IO_out;
        io_cs   = 1'b0;
        io_rd   = 1'b0;
        check(tag, d, exp);
    endtask

    initial begin
        reset   = 1'b1;
        io_cs   = 1'b0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        Address = '0;
        IO_in   = '0;
        int_ack = 1'b0;
        irq_src = 8'hFF;

        // Reset with all sources high
        tick();
        tick();
        check("rst_intr", {31'b0, intr}, 32'h0);
        chk_rd("rst_pending", BASE + 12'h0, 32'h0);
        chk_rd("rst_enable",  BASE + 12'h4, 32'h0);
        chk_rd("rst_vector",  BASE + 12'h8, 32'h0);
        chk_rd("rst_eoi_rd",  BASE + 12'hC, 32'h0);
        irq_src = 8'h00;
        tick();
        reset = 1'b0;
        tick();

        // Single channel 3
        wr(12'h4, 32'h08);
        chk_rd("en_readback", BASE + 12'h4, 32'h08);
        irq_src = 8'h08;
        tick();
        irq_src = 8'h00;
        chk_rd("single_pend", BASE + 12'h0, 32'h08);
        check("single_intr_early", {31'b0, intr}, 32'h0);
        tick();
        check("single_intr", {31'b0, intr}, 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("single_vec", BASE + 12'h8, 32'h8000_0003);
        chk_rd("single_pend_clr", BASE + 12'h0, 32'h0);
        check("single_intr_svc", {31'b0, intr}, 32'h0);
        wr(12'hC, 32'hDEAD_BEEF);
        chk_rd("single_vec_eoi", BASE + 12'h8, 32'h0);
        check("single_intr_eoi", {31'b0, intr}, 32'h0);

        // Acknowledge while idle is ignored
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("ack_idle_vec", BASE + 12'h8, 32'h0);

        // Priority: channels 5 and 2 together
        wr(12'h4, 32'hFF);
        irq_src = 8'h24;
        tick();
        irq_src = 8'h00;
        tick();
        check("prio_intr", {31'b0, intr}, 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("prio_vec2", BASE + 12'h8, 32'h8000_0002);
        chk_rd("prio_pend", BASE + 12'h0, 32'h20);
        wr(12'hC, 32'h0);
        check("prio_gap", {31'b0, intr}, 32'h0);
        tick();
        check("prio_reassert", {31'b0, intr}, 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("prio_vec5", BASE + 12'h8, 32'h8000_0005);
        chk_rd("prio_pend0", BASE + 12'h0, 32'h0);
        wr(12'hC, 32'h0);

        // Higher priority channel arriving during REQ wins at acknowledge
        irq_src = 8'h40;
        tick();
        irq_src = 8'h00;
        tick();
        check("late_intr", {31'b0, intr}, 32'h1);
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("late_vec1", BASE + 12'h8, 32'h8000_0001);
        chk_rd("late_pend", BASE + 12'h0, 32'h40);
        wr(12'hC, 32'h0);
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("late_vec6", BASE + 12'h8, 32'h8000_0006);
        wr(12'hC, 32'h0);

        // Mask while requesting
        wr(12'h4, 32'h01);
        irq_src = 8'h01;
        tick();
        irq_src = 8'h00;
        tick();
        check("mask_intr", {31'b0, intr}, 32'h1);
        wr(12'h4, 32'h00);
        tick();
        check("mask_drop", {31'b0, intr}, 32'h0);
        chk_rd("mask_pend", BASE + 12'h0, 32'h01);
        tick();
        check("mask_idle", {31'b0, intr}, 32'h0);

        // W1C race: set wins over clear of the same bit
        irq_src = 8'h02;
        tick();
        irq_src = 8'h00;
        tick();
        chk_rd("race_pre", BASE + 12'h0, 32'h03);
        irq_src = 8'h02;
        wr(12'h0, 32'h02);
        chk_rd("race_setwins", BASE + 12'h0, 32'h03);
        irq_src = 8'h00;
        wr(12'h0, 32'h03);
        chk_rd("w1c_clear", BASE + 12'h0, 32'h0);

`ifdef IOIC_LEVEL_MODE_EN
        // Level-sensitive channel 0
        wr(12'h10, 32'h01);
        chk_rd("mode_rb", BASE + 12'h10, 32'h01);
        wr(12'h4, 32'h01);
        irq_src = 8'h01;
        tick();
        tick();
        check("lvl_intr", {31'b0, intr}, 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk_rd("lvl_vec", BASE + 12'h8, 32'h8000_0000);
        chk_rd("lvl_pend_held", BASE + 12'h0, 32'h01);
        wr(12'hC, 32'h0);
        tick();
        check("lvl_reassert", {31'b0, intr}, 32'h1);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq_src = 8'h00;
        tick();
        wr(12'h0, 32'h01);
        chk_rd("lvl_w1c", BASE + 12'h0, 32'h0);
        wr(12'hC, 32'h0);
        tick();
        check("lvl_quiet", {31'b0, intr}, 32'h0);
        wr(12'h10, 32'h00);
`else
        // Offset 0x10 is outside the block without level mode
        chk_rd("no_mode_reg", BASE + 12'h10, 32'h0);
`endif

        // Reset from REQ with an acknowledge in flight
        wr(12'h4, 32'hFF);
        irq_src = 8'h10;
        tick();
        irq_src = 8'h00;
        tick();
        check("rst2_pre", {31'b0, intr}, 32'h1);
        reset   = 1'b1;
        int_ack = 1'b1;
        tick();
        reset   = 1'b0;
        int_ack = 1'b0;
        check("rst2_intr", {31'b0, intr}, 32'h0);
        chk_rd("rst2_vec",  BASE + 12'h8, 32'h0);
        chk_rd("rst2_pend", BASE + 12'h0, 32'h0);
        chk_rd("rst2_en",   BASE + 12'h4, 32'h0);
        tick();
        check("rst2_stay", {31'b0, intr}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_intr_ctrl.md
Name: io_intr_ctrl

Overview:
- Parametrised multi-channel interrupt controller for the I/O memory space; generalises the single-source intr/int_ack I/O block to NUM_CH prioritised sources.
- Sits on the CPU I/O bus (io_cs/io_rd/io_wr, ALU_OUT-derived address, D_OUT write data, DY read data) and drives the CPU intr input.
- Latches source edges into pending bits, arbitrates by fixed priority, and holds one in-service channel until software writes EOI.

Parameters:
- NUM_CH, 8, number of interrupt sources (1..32).
- ADDR_W, 12, I/O address width.
- DATA_W, 32, bus data width.
- BASE_ADDR, 12'hF00, register block base; decoded on Address[ADDR_W-1:4].

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- io_cs  in  1  I/O chip select.
- io_rd  in  1  read strobe.
- io_wr  in  1  write strobe.
- Address  in  ADDR_W  byte address; offset = Address[3:2].
- IO_in  in  DATA_W  write data.
- IO_out  out  DATA_W  read data.
- irq_src  in  NUM_CH  interrupt source lines, synchronous to clk.
- int_ack  in  1  CPU acknowledge.
- intr  out  1  interrupt request to CPU.

Behaviour:
- Synchronous active-high reset on clk: PENDING=0, ENABLE=0, VECTOR=0, src_q=0, state=IDLE, intr=0, IO_out=0.
- Select: sel = io_cs & (Address[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]).
- Register map (word offsets):
  - 0x0 PENDING: R; write-1-to-clear.
  - 0x4 ENABLE: R/W.
  - 0x8 VECTOR: R; bit31 = valid, [4:0] = in-service channel.
  - 0xC EOI: W; any data; reads return 0.
  - Bits at and above NUM_CH read 0 and ignore writes.
- Read path is combinational: IO_out = register when sel & io_rd, else 0. Zero added latency.
- Writes take effect at the clk edge where sel & io_wr.
- Edge detect: a channel's PENDING bit sets on the cycle after irq_src rises (src_q holds the previous sample). Set and W1C clear of the same bit in the same cycle: set wins.
- Pending source is req = PENDING & ENABLE. Winner = lowest set index of req.
- State machine:
  - IDLE: intr=0. If req != 0, go to REQ next cycle.
  - REQ: intr=1. If int_ack: VECTOR = {1'b1, winner}, clear PENDING[winner], go to SERVICE. If req becomes 0 without int_ack (masked or cleared): go to IDLE and drop intr.
  - SERVICE: intr=0. New edges still latch into PENDING. EOI write: VECTOR valid=0, go to IDLE. Another request can raise intr no earlier than 2 cycles after EOI.
- int_ack outside REQ is ignored. EOI outside SERVICE is ignored.
- Winner is evaluated in the int_ack cycle, not the cycle intr rose. A higher-priority channel arriving during REQ wins.
- Reset asserted in any state returns everything to reset values on the next edge; an in-flight int_ack is discarded.

Optional Feature:
- Macro IOIC_LEVEL_MODE_EN.
- Defined: adds register 0x10 MODE (R/W, reset 0). For each channel, MODE=1 makes it level-sensitive: the PENDING bit is set every cycle irq_src is high, and W1C is effective only after the source drops. Offset decode widens to Address[4:2]; BASE_ADDR is compared on Address[ADDR_W-1:5].
- Undefined: all channels are edge-sensitive and offset 0x10 is not decoded.

Test Plan:
- Reset: hold reset 2 cycles with irq_src=8'hFF -> intr=0, PENDING=0, ENABLE=0, and reads at offsets 0x0, 0x4, 0x8 return 0.
- Single channel: write ENABLE=8'h08, pulse irq_src[3] 1 cycle -> PENDING=8'h08 on the next edge, intr=1 two cycles after the pulse. int_ack -> VECTOR=32'h8000_0003, PENDING=0, intr=0. EOI write -> VECTOR=0.
- Priority: ENABLE=8'hFF, raise irq_src[5] and irq_src[2] together, then int_ack -> VECTOR[4:0]=2, PENDING=8'h20. EOI -> intr re-asserts, next int_ack -> VECTOR[4:0]=5.
- Mask while requesting: ENABLE=8'h01, pend channel 0, intr=1, then write ENABLE=0 -> intr=0 next cycle and state IDLE. PENDING still 8'h01.
- W1C race: PENDING[1]=1, write PENDING=8'h02 in the same cycle irq_src[1] rises again -> PENDING[1] stays 1.
- Level mode (macro defined): MODE=8'h01, ENABLE=8'h01, hold irq_src[0] high through int_ack/EOI -> intr re-asserts after EOI. Drop the source, then W1C -> PENDING=0 and intr stays 0.
